// File: rtl/ram_gather_pkg.sv
// ram_gather_pkg: shared size codes, FSM encodings and byte-count helper
package ram_gather_pkg;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_DONE = 2'd2;
  function automatic logic [3:0] nbytes(input logic [1:0] s);
    return 4'd1 << s;
  endfunction
endpackage

// File: rtl/ram_gather_if.sv
// ram_gather_if: load request, RAM read port and result bundle
interface ram_gather_if #(parameter int AW = 16, parameter int DW = 64);
  logic          start;
  logic [1:0]    size;
  logic          sext;
  logic [AW-1:0] addr;
  logic [7:0]    ram_q;
  logic [AW-1:0] adq;
  logic          rd;
  logic          busy;
  logic          done;
  logic [DW-1:0] q;
  modport slave(input start, size, sext, addr, ram_q, output adq, rd, busy, done, q);
  modport master(output start, size, sext, addr, ram_q, input adq, rd, busy, done, q);
endinterface

// File: rtl/ram_gather_ext.sv
// ram_ext: fills lanes above the loaded size with zero or sign bytes
module ram_ext
  import ram_gather_pkg::*;
(
  input  logic [63:0] i_raw,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  output logic [63:0] o_q
);
  logic       w_sign;
  logic [7:0] w_fill;
  logic [3:0] w_n;
  assign w_n    = nbytes(i_size);
  assign w_sign = i_size == SZ_B ? i_raw[7] : i_size == SZ_H ? i_raw[15] :
                  i_size == SZ_W ? i_raw[31] : i_raw[63];
  assign w_fill = {8{i_sext & w_sign}};
  always_comb begin
    o_q = '0;
    for (int i = 0; i < 8; i++) o_q[8*i +: 8] = 4'(i) < w_n ? i_raw[8*i +: 8] : w_fill;
  end
endmodule

// File: rtl/ram_gather.sv
// ram_gather: byte-serial RAM load, little-endian assembly with extension
module ram_gather
  import ram_gather_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 64
) (
  input logic          clk,
  input logic          rst,
  ram_gather_if.slave  bus
);
  logic [1:0]    r_state, r_size;
  logic          r_sext, r_rd;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_adq;
  logic [63:0]   r_asm;
  logic [DW-1:0] r_q;
  logic [63:0]   w_asm, w_ext;
  logic [3:0]    w_n;
  logic [2:0]    w_lane;
  logic          w_accept;
  assign w_n      = nbytes(r_size);
  assign w_lane   = 3'(r_cnt - 4'd1);
  assign w_accept = bus.start && r_state != ST_FETCH;
  // byte returned this cycle belongs to the address issued in the previous one
  always_comb begin
    w_asm = r_asm;
    if (r_cnt != 4'd0) w_asm[{w_lane, 3'b000} +: 8] = bus.ram_q;
  end
  ram_ext u_ext (.i_raw(w_asm), .i_size(r_size), .i_sext(r_sext), .o_q(w_ext));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_size  <= SZ_B;
      r_sext  <= 1'b0;
      r_rd    <= 1'b0;
      r_cnt   <= 4'd0;
      r_adq   <= '0;
      r_asm   <= '0;
      r_q     <= '0;
    end else if (w_accept) begin
      r_size  <= bus.size;
      r_sext  <= bus.sext;
      r_adq   <= bus.addr;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b1;
      r_state <= ST_FETCH;
    end else if (r_state == ST_FETCH) begin
      r_asm <= w_asm;
      if (r_cnt + 4'd1 < w_n) r_adq <= r_adq + 1'b1;
      if (r_cnt == w_n) begin
        r_state <= ST_DONE;
        r_q     <= w_ext;
        r_rd    <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
        r_rd  <= r_cnt + 4'd1 < w_n;
      end
    end else if (r_state == ST_DONE) r_state <= ST_IDLE;
  end
  assign bus.adq  = r_adq;
  assign bus.rd   = r_rd;
  assign bus.busy = r_state == ST_FETCH;
  assign bus.done = r_state == ST_DONE;
  assign bus.q    = r_q;
endmodule

// File: tb/tb_ram_gather.sv
// tb_ram_gather: directed checks of ram_gather against hand-computed results
module tb_ram_gather;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0]  mem [0:65535];
  logic [15:0] adq_l  [0:15];
  logic        rd_l   [0:15];
  logic        busy_l [0:15];
  logic        done_l [0:15];
  logic [63:0] q_l    [0:15];
  ram_gather_if #(.AW(16), .DW(64)) bus ();
  ram_gather #(.AW(16), .DW(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.ram_q <= mem[bus.adq];

  task automatic launch(input logic [15:0] a, input logic [1:0] s, input logic x, input int ncyc,
                        input int inj_k, input logic [15:0] ia, input logic [1:0] is, input logic ix);
    @(negedge clk);
    bus.start = 1'b1; bus.addr = a; bus.size = s; bus.sext = x;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      adq_l[k] = bus.adq; rd_l[k] = bus.rd; busy_l[k] = bus.busy; done_l[k] = bus.done; q_l[k] = bus.q;
      bus.start = 1'b0;
      if (k == inj_k) begin
        bus.start = 1'b1; bus.addr = ia; bus.size = is; bus.sext = ix;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.addr = 16'h1234; bus.size = 2'b11; bus.sext = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.adq, bus.rd, bus.busy, bus.done} !== 19'd0 || bus.q !== 64'd0) begin
      errors++;
      $display("FAIL reset: adq=%h rd=%b busy=%b done=%b q=%h, want all zero", bus.adq, bus.rd, bus.busy, bus.done, bus.q);
    end
    bus.start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_byte();
    int nrd, ndone;
    mem[16'h0010] = 8'h80;
    launch(16'h0010, 2'b00, 1'b1, 5, 0, 0, 0, 0);
    nrd = 0; ndone = 0;
    for (int k = 1; k <= 5; k++) begin nrd += int'(rd_l[k]); ndone += int'(done_l[k]); end
    checks++;
    if (rd_l[1] !== 1'b1 || adq_l[1] !== 16'h0010 || nrd != 1) begin
      errors++; $display("FAIL byte_addr: adq=%h rd=%b rd_cycles=%0d, want 0010 1 1", adq_l[1], rd_l[1], nrd);
    end
    checks++;
    if (done_l[3] !== 1'b1 || ndone != 1) begin
      errors++; $display("FAIL byte_done: done@3=%b pulses=%0d, want 1 1", done_l[3], ndone);
    end
    checks++;
    if (q_l[3] !== 64'hFFFF_FFFF_FFFF_FF80) begin
      errors++; $display("FAIL byte_sext: q=%h want ffffffffffffff80", q_l[3]);
    end
    launch(16'h0010, 2'b00, 1'b0, 4, 0, 0, 0, 0);
    checks++;
    if (done_l[3] !== 1'b1 || q_l[3] !== 64'h80) begin
      errors++; $display("FAIL byte_zext: done=%b q=%h want 1 0000000000000080", done_l[3], q_l[3]);
    end
  endtask

  task automatic test_dword();
    int nbusy;
    logic ok;
    for (int i = 0; i < 8; i++) mem[16'h0100 + 16'(i)] = 8'(i + 1);
    launch(16'h0100, 2'b11, 1'b0, 12, 0, 0, 0, 0);
    ok = 1'b1; nbusy = 0;
    for (int k = 1; k <= 8; k++) if (adq_l[k] !== 16'h0100 + 16'(k - 1) || rd_l[k] !== 1'b1) ok = 1'b0;
    for (int k = 1; k <= 12; k++) nbusy += int'(busy_l[k]);
    checks++;
    if (!ok || rd_l[9] !== 1'b0) begin
      errors++; $display("FAIL dword_addr: adq1=%h adq8=%h rd9=%b, want 0100 0107 0", adq_l[1], adq_l[8], rd_l[9]);
    end
    checks++;
    if (nbusy != 9) begin errors++; $display("FAIL dword_busy: busy cycles=%0d want 9", nbusy); end
    checks++;
    if (q_l[5] !== 64'h80) begin errors++; $display("FAIL dword_hold: mid-fetch q=%h want 0000000000000080", q_l[5]); end
    checks++;
    if (done_l[10] !== 1'b1 || q_l[10] !== 64'h0807_0605_0403_0201) begin
      errors++; $display("FAIL dword_q: done@10=%b q=%h want 1 0807060504030201", done_l[10], q_l[10]);
    end
  endtask

  task automatic test_wrap();
    mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB; mem[16'h0000] = 8'hCC; mem[16'h0001] = 8'hDD;
    launch(16'hFFFE, 2'b10, 1'b0, 7, 0, 0, 0, 0);
    checks++;
    if ({adq_l[1], adq_l[2], adq_l[3], adq_l[4]} !== 64'hFFFE_FFFF_0000_0001) begin
      errors++; $display("FAIL wrap_addr: %h %h %h %h want fffe ffff 0000 0001", adq_l[1], adq_l[2], adq_l[3], adq_l[4]);
    end
    checks++;
    if (done_l[6] !== 1'b1 || q_l[6] !== 64'h0000_0000_DDCC_BBAA) begin
      errors++; $display("FAIL wrap_q: done@6=%b q=%h want 1 00000000ddccbbaa", done_l[6], q_l[6]);
    end
  endtask

  task automatic test_ignored_start();
    int ndone;
    mem[16'h0200] = 8'h11; mem[16'h0201] = 8'h92; mem[16'h0300] = 8'h55; mem[16'h0301] = 8'h66;
    launch(16'h0200, 2'b01, 1'b1, 8, 1, 16'h0300, 2'b01, 1'b0);
    ndone = 0;
    for (int k = 1; k <= 8; k++) ndone += int'(done_l[k]);
    checks++;
    if ({adq_l[1], adq_l[2], adq_l[3]} !== 48'h0200_0201_0201) begin
      errors++; $display("FAIL ign_addr: %h %h %h want 0200 0201 0201", adq_l[1], adq_l[2], adq_l[3]);
    end
    checks++;
    if (done_l[4] !== 1'b1 || ndone != 1 || q_l[8] !== 64'hFFFF_FFFF_FFFF_9211) begin
      errors++; $display("FAIL ign_q: done@4=%b pulses=%0d q=%h want 1 1 ffffffffffff9211", done_l[4], ndone, q_l[8]);
    end
  endtask

  task automatic test_back_to_back();
    mem[16'h0400] = 8'h01; mem[16'h0401] = 8'h02; mem[16'h0402] = 8'h03; mem[16'h0403] = 8'h84;
    mem[16'h0500] = 8'h7F;
    launch(16'h0400, 2'b10, 1'b1, 11, 6, 16'h0500, 2'b00, 1'b0);
    checks++;
    if (done_l[6] !== 1'b1 || q_l[6] !== 64'hFFFF_FFFF_8403_0201) begin
      errors++; $display("FAIL b2b_first: done@6=%b q=%h want 1 ffffffff84030201", done_l[6], q_l[6]);
    end
    checks++;
    if (busy_l[7] !== 1'b1 || rd_l[7] !== 1'b1 || adq_l[7] !== 16'h0500 || q_l[7] !== 64'hFFFF_FFFF_8403_0201) begin
      errors++; $display("FAIL b2b_resume: busy=%b rd=%b adq=%h q=%h want 1 1 0500 ffffffff84030201", busy_l[7], rd_l[7], adq_l[7], q_l[7]);
    end
    checks++;
    if (done_l[9] !== 1'b1 || q_l[9] !== 64'h7F || done_l[10] !== 1'b0) begin
      errors++; $display("FAIL b2b_second: done@9=%b q=%h done@10=%b want 1 000000000000007f 0", done_l[9], q_l[9], done_l[10]);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    launch(16'h0100, 2'b11, 1'b0, 3, 0, 0, 0, 0);
    checks++;
    if (busy_l[3] !== 1'b1 || q_l[3] !== 64'h7F) begin
      errors++; $display("FAIL rstmid_pre: busy=%b q=%h want 1 000000000000007f", busy_l[3], q_l[3]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.adq, bus.rd, bus.busy, bus.done} !== 19'd0 || bus.q !== 64'd0) begin
      errors++; $display("FAIL rstmid: adq=%h rd=%b busy=%b done=%b q=%h want all zero", bus.adq, bus.rd, bus.busy, bus.done, bus.q);
    end
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin @(negedge clk); ndone += int'(bus.done) + int'(bus.busy); end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL rstmid_after: done/busy cycles=%0d want 0", ndone); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    bus.start = 1'b0; bus.addr = '0; bus.size = 2'b00; bus.sext = 1'b0;
    test_reset();
    test_byte();
    test_dword();
    test_wrap();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_gather.md
# ram_gather

Load-side counterpart of the byte-serial RAM store path. Takes a load request from the EXE stage and issues consecutive byte addresses to the byte-wide synchronous RAM. Assembles the returned bytes little-endian into a 64-bit result, applies zero or sign extension, and reports completion to the control FSM. It sits between the RAM read port and the register write-back mux, and shares the RAM address bus with the store loader.

## Interface
Parameters:
- AW, 16, RAM address width
- DW, 64, assembled result width (fixed at 8 bytes)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  load request, sampled on the rising edge when state ≠ FETCH
- size  in  2  byte count: 00=1, 01=2, 10=4, 11=8
- sext  in  1  1 = sign-extend, 0 = zero-extend
- addr  in  AW  base byte address
- ram_q  in  8  RAM read data, valid one cycle after its address is presented
- adq  out  AW  RAM address
- rd  out  1  RAM read strobe
- busy  out  1  high while fetching; control FSM holds its state while busy=1
- done  out  1  one-cycle completion pulse
- q  out  DW  assembled, extended result

## Operation
- States: IDLE, FETCH, DONE. Byte counter cnt is 4 bits, range 0..N, where N = bytes for the latched size.
- Start acceptance: start is accepted in IDLE or DONE. On acceptance:
  - latch size, sext, addr
  - adq←addr, cnt←0, state←FETCH
- start is ignored in FETCH.
- FETCH, cycle with cnt=c:
  - rd=1 when c<N.
  - When c≥1, ram_q is written to byte lane c−1 of the assembly register.
  - When c<N−1, adq←adq+1. Otherwise adq holds.
  - When c=N, the last byte is captured and state←DONE. Otherwise cnt←c+1.
- Transition into DONE:
  - q←assembly register with lanes N..7 filled.
  - Fill value is 0xFF when sext=1 and bit 7 of lane N−1 is 1. Otherwise the fill is 0x00.
- DONE: done=1 for exactly one cycle, then IDLE, unless a new start is accepted.
- q holds its value until the next DONE transition. q is never updated mid-fetch.
- Address arithmetic is modulo 2^AW: 0xFFFF+1 wraps to 0x0000.
- busy=1 exactly when state=FETCH. done=1 exactly when state=DONE.

## Timing
- Reset values: adq=0, q=0, rd=0, busy=0, done=0, state=IDLE, cnt=0.
- Reset mid-fetch aborts the transfer. All outputs return to reset values on the next edge, and q is cleared.
- Latency: start sampled at edge E0.
  - FETCH occupies cycles E0+1 .. E0+N+1.
  - done is high during cycle E0+N+2.
- Resulting start-to-done latency: 3 cycles for a byte, 4 for a halfword, 6 for a word, 10 for a doubleword.
- Back-to-back: start during the DONE cycle is accepted. The next FETCH begins the following cycle, giving no idle gap.
- rd and adq are registered outputs. There is no combinational path from start or addr to adq.
- rst has priority over start when both are high on the same edge.

## Structure
- The size codes (SZ_B/SZ_H/SZ_W/SZ_D) and the IDLE/FETCH/DONE encodings belong in the shared data define header, next to the CPU state codes. The store loader uses the same size codes.
- One combinational sub-module, ram_ext, is natural: it takes the raw 64-bit assembly, size and sext, and produces the extended result.
- Everything else is a single FSM, counter and address register.

## Test plan
- **Byte, sign-extend:** RAM[0x0010]=0x80, size=00, sext=1, start.
  - Required: adq=0x0010 with rd=1 for one cycle.
  - done at start+3, q=0xFFFF_FFFF_FFFF_FF80.
  - Repeating with sext=0 gives q=0x80.
- **Doubleword:** RAM[0x0100..0x0107]=01..08, size=11.
  - Required: adq steps 0x0100..0x0107.
  - done at start+10, q=0x0807_0605_0403_0201, busy high for 9 cycles.
- **Wrap:** word load at addr=0xFFFE, RAM bytes AA BB CC DD, sext=0.
  - Required: adq sequence FFFE, FFFF, 0000, 0001.
  - q=0x0000_0000_DDCC_BBAA.
- **Ignored start:** halfword load, with start re-pulsed (different addr) during FETCH.
  - Required: the second request is dropped, adq is unaffected, and q reflects the first address only.
- **Back-to-back:** start a byte load in the DONE cycle of a word load.
  - Required: FETCH resumes on the next cycle.
  - Both done pulses appear, q updates after each.
- **Reset mid-operation:** assert rst on cycle 3 of a doubleword FETCH.
  - Required: busy=0, done=0, q=0, adq=0 next cycle, with no done pulse afterwards.
